// File: rtl/libstf_axis_pkg.sv
// Shared AXI4-Stream widths and the wide-beat payload type used by the 256->512 packer.
// The optional keep checker in axis_beat_packer is enabled with AXIS_PACKER_CHECK_EN.
package libstf_axis_pkg;

  localparam int AXIS_NARROW_BITS = 256;
  localparam int AXIS_WIDE_BITS   = 512;
  localparam int AXIS_NARROW_KEEP = AXIS_NARROW_BITS / 8;
  localparam int AXIS_WIDE_KEEP   = AXIS_WIDE_BITS / 8;

  typedef struct packed {
    logic [AXIS_WIDE_BITS-1:0] data;
    logic [AXIS_WIDE_KEEP-1:0] keep;
    logic                      last;
  } axis_wide_beat_t;

  typedef enum logic {
    PK_EMPTY   = 1'b0,
    PK_HAVE_LO = 1'b1
  } pack_state_e;

  // Builds a wide beat from an upper and a lower narrow half.
  function automatic axis_wide_beat_t pack_pair(
    input logic [AXIS_NARROW_BITS-1:0] hi_data,
    input logic [AXIS_NARROW_KEEP-1:0] hi_keep,
    input logic [AXIS_NARROW_BITS-1:0] lo_data,
    input logic [AXIS_NARROW_KEEP-1:0] lo_keep,
    input logic                        last
  );
    axis_wide_beat_t b;
    b.data = {hi_data, lo_data};
    b.keep = {hi_keep, lo_keep};
    b.last = last;
    return b;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry registered output slice for wide AXI4-Stream beats.
// A load replaces the payload and keeps valid set; a drain without load clears valid.
module axis_out_reg
  import libstf_axis_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  axis_wide_beat_t i_beat,
  input  logic            i_ready,
  output logic            o_valid,
  output axis_wide_beat_t o_beat,
  output logic            o_can_load
);

  logic            r_valid;
  axis_wide_beat_t r_beat;

  // The slot may be written when it is empty or being drained this cycle.
  assign o_can_load = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_beat  <= i_beat;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_beat  = r_beat;

endmodule

// File: rtl/axis_beat_packer.sv
// Packs pairs of 256-bit AXI4-Stream beats into 512-bit beats (first beat = lower half).
// Define AXIS_PACKER_CHECK_EN to add the sticky err flag for partial-keep non-last beats.
module axis_beat_packer
  import libstf_axis_pkg::*;
#(
  parameter int IN_WIDTH  = AXIS_NARROW_BITS,
  parameter int OUT_WIDTH = AXIS_WIDE_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IN_WIDTH-1:0]    i_in_tdata,
  input  logic [IN_WIDTH/8-1:0]  i_in_tkeep,
  input  logic                   i_in_tlast,
  input  logic                   i_in_tvalid,
  output logic                   o_in_tready,
  output logic [OUT_WIDTH-1:0]   o_out_tdata,
  output logic [OUT_WIDTH/8-1:0] o_out_tkeep,
  output logic                   o_out_tlast,
  output logic                   o_out_tvalid,
  input  logic                   i_out_tready,
  output logic                   o_have_lo
`ifdef AXIS_PACKER_CHECK_EN
  ,output logic                  err
`endif
);

  if (IN_WIDTH != AXIS_NARROW_BITS) begin : g_bad_in_width
    $error("axis_beat_packer: IN_WIDTH must be 256");
  end
  if (OUT_WIDTH != AXIS_WIDE_BITS) begin : g_bad_out_width
    $error("axis_beat_packer: OUT_WIDTH must be 512");
  end

  // Handshake: a beat moves when valid && ready at a rising edge. in.tready is a
  // function of reset and output-slot occupancy only, never of in.tvalid or in.tlast.
  pack_state_e                 r_state;
  pack_state_e                 w_state_nxt;
  logic [AXIS_NARROW_BITS-1:0] r_lo_data;
  logic [AXIS_NARROW_KEEP-1:0] r_lo_keep;
  logic                        w_accept;
  logic                        w_load;
  logic                        w_can_load;
  logic                        w_out_valid;
  axis_wide_beat_t             w_beat;
  axis_wide_beat_t             w_out_beat;

  assign o_in_tready = !rst && w_can_load;
  assign w_accept    = i_in_tvalid && o_in_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PK_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_beat      = '0;
    case (r_state)
      PK_EMPTY: begin
        if (w_accept) begin
          if (i_in_tlast) begin
            w_load = 1'b1;
            w_beat = pack_pair('0, '0, i_in_tdata, i_in_tkeep, 1'b1);
          end else begin
            w_state_nxt = PK_HAVE_LO;
          end
        end
      end
      PK_HAVE_LO: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_beat      = pack_pair(i_in_tdata, i_in_tkeep, r_lo_data, r_lo_keep, i_in_tlast);
          w_state_nxt = PK_EMPTY;
        end
      end
      default: begin
        w_state_nxt = PK_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo_data <= '0;
      r_lo_keep <= '0;
    end else if (w_accept && (r_state == PK_EMPTY) && !i_in_tlast) begin
      r_lo_data <= i_in_tdata;
      r_lo_keep <= i_in_tkeep;
    end
  end

  axis_out_reg u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_beat     (w_beat),
    .i_ready    (i_out_tready),
    .o_valid    (w_out_valid),
    .o_beat     (w_out_beat),
    .o_can_load (w_can_load)
  );

  assign o_out_tvalid = w_out_valid;
  assign o_out_tdata  = w_out_beat.data;
  assign o_out_tkeep  = w_out_beat.keep;
  assign o_out_tlast  = w_out_beat.last;
  assign o_have_lo    = (r_state == PK_HAVE_LO);

`ifdef AXIS_PACKER_CHECK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept && !i_in_tlast && (i_in_tkeep != {AXIS_NARROW_KEEP{1'b1}})) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_axis_beat_packer.sv
// Directed bench for axis_beat_packer: pairing, lone-last, odd packets, streaming,
// random output backpressure, mid-packet reset and (with AXIS_PACKER_CHECK_EN) err.
module tb_axis_beat_packer;

  localparam int W = 577;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] i_in_tdata = '0;
  logic [31:0]  i_in_tkeep = '0;
  logic         i_in_tlast = 1'b0;
  logic         i_in_tvalid = 1'b0;
  logic         o_in_tready;
  logic [511:0] o_out_tdata;
  logic [63:0]  o_out_tkeep;
  logic         o_out_tlast;
  logic         o_out_tvalid;
  logic         i_out_tready = 1'b1;
  logic         o_have_lo;
`ifdef AXIS_PACKER_CHECK_EN
  logic         err;
`endif

  axis_beat_packer dut (
    .clk          (clk),
    .rst          (rst),
    .i_in_tdata   (i_in_tdata),
    .i_in_tkeep   (i_in_tkeep),
    .i_in_tlast   (i_in_tlast),
    .i_in_tvalid  (i_in_tvalid),
    .o_in_tready  (o_in_tready),
    .o_out_tdata  (o_out_tdata),
    .o_out_tkeep  (o_out_tkeep),
    .o_out_tlast  (o_out_tlast),
    .o_out_tvalid (o_out_tvalid),
    .i_out_tready (i_out_tready),
    .o_have_lo    (o_have_lo)
`ifdef AXIS_PACKER_CHECK_EN
    ,.err         (err)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int out_count = 0;
  bit rand_mode = 1'b0;
  bit expect_no_wait = 1'b0;

  logic [W-1:0] exp_q[$];

  logic         m_have_lo = 1'b0;
  logic [255:0] m_lo_d = '0;
  logic [31:0]  m_lo_k = '0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [511:0] d, input logic [63:0] k, input logic l);
    return {d, k, l};
  endfunction

  // driver: called at negedge+1; returns at negedge+1 after the accepting edge
  task automatic send(input logic [255:0] d, input logic [31:0] k, input logic l);
    int waited;
    i_in_tdata  = d;
    i_in_tkeep  = k;
    i_in_tlast  = l;
    i_in_tvalid = 1'b1;
    waited = 0;
    while (!o_in_tready && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("in_accept", o_in_tready, 1);
    if (expect_no_wait) chk("stream_rdy", waited, 0);
    if (!m_have_lo) begin
      if (l) exp_q.push_back(mk({256'b0, d}, {32'b0, k}, 1'b1));
      else begin
        m_lo_d = d; m_lo_k = k; m_have_lo = 1'b1;
      end
    end else begin
      exp_q.push_back(mk({d, m_lo_d}, {k, m_lo_k}, l));
      m_have_lo = 1'b0;
    end
    @(negedge clk); #1;
  endtask

  task automatic idle();
    i_in_tvalid = 1'b0;
    i_in_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(negedge clk); #1; end
    chk("rst_tvalid", o_out_tvalid, 0);
    chk("rst_have_lo", o_have_lo, 0);
    chk("rst_tready", o_in_tready, 0);
    exp_q.delete();
    m_have_lo = 1'b0;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // scoreboard / monitor: sets out.tready, then samples 1 time unit later
  bit           hold = 1'b0;
  logic [W-1:0] held;
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
      i_out_tready = 1'b1;
    end else begin
      if (hold) chk("stall_stable", {o_out_tvalid, o_out_tdata, o_out_tkeep, o_out_tlast}, {1'b1, held});
      i_out_tready = rand_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
      #1;
      if (o_out_tvalid && i_out_tready) begin
        hold = 1'b0;
        out_count++;
        chk("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("out_beat", {o_out_tdata, o_out_tkeep, o_out_tlast}, exp_q.pop_front());
      end else if (o_out_tvalid) begin
        chk("stall_tready_low", o_in_tready, 0);
        hold = 1'b1;
        held = {o_out_tdata, o_out_tkeep, o_out_tlast};
      end else begin
        hold = 1'b0;
      end
    end
  end

  logic [255:0] da, db, dc;
  int cnt0;

  initial begin
    da = {8{32'hAAAA_AAAA}};
    db = {8{32'hBBBB_BBBB}};
    dc = {8{32'hCCCC_CCCC}};

    // reset state
    repeat (2) begin @(negedge clk); #1; end
    chk("reset_tvalid", o_out_tvalid, 0);
    chk("reset_tlast", o_out_tlast, 0);
    chk("reset_tkeep", o_out_tkeep, 0);
    chk("reset_tdata", o_out_tdata, 0);
    chk("reset_have_lo", o_have_lo, 0);
    chk("reset_tready", o_in_tready, 0);
`ifdef AXIS_PACKER_CHECK_EN
    chk("reset_err", err, 0);
`endif
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_reset_tready", o_in_tready, 1);

    // two-beat packet, latency one cycle
    send(da, 32'hFFFF_FFFF, 1'b0);
    chk("pair_have_lo", o_have_lo, 1);
    chk("pair_no_out_yet", o_out_tvalid, 0);
    send(db, 32'hFFFF_FFFF, 1'b1);
    idle();
    chk("pair_valid", o_out_tvalid, 1);
    chk("pair_data", o_out_tdata, {db, da});
    chk("pair_keep", o_out_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pair_last", o_out_tlast, 1);
    @(negedge clk); #1;
    chk("pair_one_beat", o_out_tvalid, 0);

    // single-beat packet
    send(256'h1234, 32'h0000_000F, 1'b1);
    idle();
    chk("single_data", o_out_tdata, 512'h1234);
    chk("single_keep", o_out_tkeep, 64'h0000_0000_0000_000F);
    chk("single_last", o_out_tlast, 1);

    // three-beat packet
    send(da, 32'hFFFF_FFFF, 1'b0);
    send(db, 32'hFFFF_FFFF, 1'b0);
    chk("odd_first_data", o_out_tdata, {db, da});
    chk("odd_first_keep", o_out_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("odd_first_last", o_out_tlast, 0);
    send(dc, 32'hFFFF_FFFF, 1'b1);
    idle();
    chk("odd_second_data", o_out_tdata, {256'b0, dc});
    chk("odd_second_keep", o_out_tkeep, 64'h0000_0000_FFFF_FFFF);
    chk("odd_second_last", o_out_tlast, 1);
    drain();

    // streaming 100 beats with out.tready held high
    cnt0 = out_count;
    expect_no_wait = 1'b1;
    for (int p = 0; p < 50; p++) begin
      send({8{$urandom()}}, 32'hFFFF_FFFF, 1'b0);
      send({8{$urandom()}}, 32'hFFFF_FFFF, 1'b1);
    end
    idle();
    expect_no_wait = 1'b0;
    drain();
    chk("stream_out_count", out_count - cnt0, 50);

    // random backpressure, packets of 1..4 beats
    rand_mode = 1'b1;
    for (int p = 0; p < 20; p++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        if (b == len - 1) send({$urandom(), 224'h0} | 256'($urandom()), 32'($urandom()), 1'b1);
        else send({8{$urandom()}}, 32'hFFFF_FFFF, 1'b0);
      end
      if ($urandom_range(0, 3) == 0) begin idle(); @(negedge clk); #1; end
    end
    idle();
    drain();
    rand_mode = 1'b0;
    @(negedge clk); #1;

`ifdef AXIS_PACKER_CHECK_EN
    chk("err_clean_traffic", err, 0);
`endif

    // reset mid-packet, then a lone tlast beat
    send(da, 32'hFFFF_FFFF, 1'b0);
    idle();
    chk("mid_have_lo", o_have_lo, 1);
    do_reset();
    @(negedge clk); #1;
    send(256'h55, 32'h0000_0001, 1'b1);
    idle();
    chk("after_rst_data", o_out_tdata, 512'h55);
    chk("after_rst_keep", o_out_tkeep, 64'h1);
    chk("after_rst_last", o_out_tlast, 1);
    drain();

`ifdef AXIS_PACKER_CHECK_EN
    chk("err_before", err, 0);
    send(da, 32'h7FFF_FFFF, 1'b0);
    chk("err_set", err, 1);
    send(db, 32'hFFFF_FFFF, 1'b1);
    idle();
    repeat (3) begin @(negedge clk); #1; end
    chk("err_sticky", err, 1);
    do_reset();
    @(negedge clk); #1;
    chk("err_cleared", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_beat_packer.md
# axis_beat_packer

Packs a 256-bit AXI4-Stream into a 512-bit AXI4-Stream by pairing consecutive input beats: the first beat goes to the lower half, the second to the upper half. It sits between 256-bit producers and the 512-bit datapath, as the inverse of the 512→256 downsizing stage. Odd-length packets are closed with a half-empty beat whose upper `tkeep` is zero. The output is registered and the block sustains one input beat per cycle.

## Interface
- `IN_WIDTH`, taken from `in.AXI4S_DATA_BITS`; must be 256 (elaboration assert).
- `OUT_WIDTH`, taken from `out.AXI4S_DATA_BITS`; must be 512 (elaboration assert).
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in`  AXI4S.s  256/32  input stream: `tdata`, `tkeep`, `tlast`, `tvalid`, `tready`.
- `out`  AXI4S.m  512/64  packed output stream, registered.
- `err`  out  1  sticky keep-check error flag; present only with `AXIS_PACKER_CHECK_EN`.

## Operation
- State:
  - `have_lo`: lower half occupied.
  - `lo_data[255:0]`, `lo_keep[31:0]`: held lower half.
  - Output register: `out_data`, `out_keep`, `out_last`, `out_valid`.
- `in.tready = !rst && (!out_valid || out.tready)`. It never depends on `in.tvalid`.
- An input beat is accepted when `in.tvalid && in.tready`. On acceptance:
  - `!have_lo && !in.tlast`: store the beat in `lo_*`; set `have_lo`. Output register unchanged, unless it drains this cycle.
  - `!have_lo && in.tlast`: load the output register with data `{256'b0, in.tdata}`, keep `{32'b0, in.tkeep}`, last 1.
  - `have_lo`: load the output register with data `{in.tdata, lo_data}`, keep `{in.tkeep, lo_keep}`, last `in.tlast`. Clear `have_lo`.
- Output handshake:
  - When `out_valid && out.tready` and no load occurs in the same cycle, clear `out_valid`.
  - A load in the same cycle replaces the register and keeps `out_valid` set.
- `out.tdata`, `out.tkeep`, `out.tlast` and `out.tvalid` are driven directly from the output register.
- `tkeep` bits pass through unchanged. No compaction is done; sparse keep inside a beat is preserved.
- `tlast` on the first half of a pair closes the packet immediately. A new packet always starts in the lower half.

## Timing
- Reset values: `out.tvalid=0`, `out.tlast=0`, `out.tkeep=0`, `out.tdata=0`, `have_lo=0`, `err=0`. `in.tready=0` while `rst` is high and 1 on the first cycle after reset.
- Latency is one cycle from acceptance of the completing input beat (second of a pair, or a lone `tlast` beat) to `out.tvalid`.
- Throughput: with `out.tready` held at 1, one input beat is accepted every cycle and one output beat appears every two cycles. No bubbles.
- Backpressure:
  - `out.tready=0` with `out_valid=1` drops `in.tready` in the same cycle.
  - A lower-half beat is also held off during this stall. This is intentional: it keeps `tready` free of combinational dependence on input `tlast`.
- While `out.tvalid && !out.tready`, the output payload must remain stable (AXI rule).
- Reset mid-packet discards `lo_*` and any pending output beat. The next accepted beat starts a new lower half.
- The input stream is never split across the reset edge; any beat presented during reset is not accepted.

## Configuration
- `AXIS_PACKER_CHECK_EN` defined:
  - `err` port and its logic are compiled in.
  - `err` sets on the cycle after accepting any input beat with `!in.tlast && in.tkeep != 32'hFFFF_FFFF`.
  - `err` is sticky and cleared only by `rst`.
  - Data path behaviour is unchanged.
- `AXIS_PACKER_CHECK_EN` undefined: no `err` port and no check logic.

## Structure
- Shared package `libstf_axis_pkg` holds:
  - `AXIS_NARROW_BITS=256`, `AXIS_WIDE_BITS=512`, with derived keep widths 32/64.
  - Typedef `axis_wide_beat_t` (data, keep, last) for the output register.
- One sub-module, `axis_out_reg`: a one-entry output register slice (valid/ready, load/drain) carrying `axis_wide_beat_t`. Packing and `have_lo` logic stay in the top.

## Test plan
- Two-beat packet, D0=0xA…A keep all-ones, then D1=0xB…B tlast, `out.tready=1` -> one output beat: data `{B,A}`, keep `64'hFFFF_FFFF_FFFF_FFFF`, last 1, valid exactly one cycle after D1 is accepted.
- Single-beat packet, data 0x1234, keep `32'h0000_000F`, tlast -> output data `{256'b0, …1234}`, keep `64'h0000_0000_0000_000F`, last 1.
- Three-beat packet, keep all-ones -> two outputs: first full, last 0; second keep `64'h0000_0000_FFFF_FFFF`, last 1.
- Streaming 100 beats of 2-beat packets with `out.tready` held at 1 -> `in.tready` constant 1, 50 outputs, every output beat exactly matches the concatenated input pair.
- `out.tready` random at 30% -> no loss or duplication, output stable while stalled, `in.tready` low whenever the output is stalled.
- Assert `rst` after the first beat of a pair, then send a lone tlast beat 0x55 -> output contains only 0x55 in the lower half. With `AXIS_PACKER_CHECK_EN`, a non-last beat with keep `32'h7FFF_FFFF` sets `err`, which stays 1 until `rst`.
